// File: rtl/wb_cmd_pkg.sv
// Shared types for the Wishbone command master: opcodes, FSM states and
// the timeout counter sizing helper.
package wb_cmd_pkg;

    typedef enum logic [1:0] {
        OP_WRITE    = 2'b00,
        OP_READ     = 2'b01,
        OP_WAIT_IRQ = 2'b10,
        OP_RSVD     = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        IRQ  = 2'b10,
        RESP = 2'b11
    } state_t;

    // Counter must be able to hold TIMEOUT itself.
    function automatic int unsigned tmo_width(input int unsigned timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/wb_cmd_master_if.sv
// Wishbone classic-cycle bus between the command master and a slave port.
interface wb_cmd_master_if #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] wdat;
    logic [DATA_WIDTH-1:0] rdat;
    logic                  ack;

    modport master (output cyc, stb, we, adr, wdat, input rdat, ack);
    modport slave  (input cyc, stb, we, adr, wdat, output rdat, ack);
endinterface

// File: rtl/wb_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; DEPTH must be a power of 2.
module wb_cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Power-of-2 depth lets the pointers wrap by plain overflow.
        if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic-cycle master: queues WRITE/READ/WAIT_IRQ commands and
// returns one response per command, with ack/irq timeout detection.
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic [1:0]                    cmd_op_i,
    input  logic [ADDR_WIDTH-1:0]         cmd_adr_i,
    input  logic [DATA_WIDTH-1:0]         cmd_dat_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [1:0]                    rsp_op_o,
    output logic [DATA_WIDTH-1:0]         rsp_dat_o,
    output logic                          rsp_err_o,
    wb_cmd_master_if.master               wb,
    input  logic                          irq_i,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
    typedef struct packed {
        op_t                   op;
        logic [ADDR_WIDTH-1:0] adr;
        logic [DATA_WIDTH-1:0] dat;
    } cmd_t;

    localparam int unsigned CmdW = $bits(cmd_t);
    localparam int unsigned TmoW = tmo_width(TIMEOUT);

    cmd_t            cmd_in, cmd_head;
    logic [CmdW-1:0] fifo_rdata;
    logic            fifo_full, fifo_empty, fifo_push, fifo_pop;

    state_t                state_q, state_d;
    logic                  cyc_q, cyc_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
    logic                  rsp_valid_q, rsp_valid_d;
    op_t                   rsp_op_q, rsp_op_d;
    logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [TmoW-1:0]       tmo_q, tmo_d;
    logic                  tmo_hit;

    assign cmd_in = '{op: op_t'(cmd_op_i), adr: cmd_adr_i, dat: cmd_dat_i};
    assign cmd_head = cmd_t'(fifo_rdata);

    // Ready is held low while reset is asserted so nothing is accepted then.
    assign cmd_ready_o = rst_i & ~fifo_full;
    assign fifo_push   = cmd_valid_i & cmd_ready_o;

    wb_cmd_fifo #(
        .WIDTH (CmdW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .data_i  (cmd_in),
        .pop_i   (fifo_pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count_o)
    );

    // The wait that would bring the count to TIMEOUT is the last one allowed.
    assign tmo_hit = (32'(tmo_q) + 32'd1) >= TIMEOUT;

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        wdat_d      = wdat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_op_d    = rsp_op_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        tmo_d       = tmo_q;
        fifo_pop    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    tmo_d    = '0;
                    rsp_op_d = cmd_head.op;
                    case (cmd_head.op)
                        OP_WRITE: begin
                            state_d = BUS;
                            cyc_d   = 1'b1;
                            we_d    = 1'b1;
                            adr_d   = cmd_head.adr;
                            wdat_d  = cmd_head.dat;
                        end
                        OP_READ: begin
                            state_d = BUS;
                            cyc_d   = 1'b1;
                            we_d    = 1'b0;
                            adr_d   = cmd_head.adr;
                            wdat_d  = '0;
                        end
                        OP_WAIT_IRQ: state_d = IRQ;
                        default: begin
                            state_d     = RESP;
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b1;
                            rsp_dat_d   = '0;
                        end
                    endcase
                end
            end
            BUS: begin
                if (wb.ack || tmo_hit) begin
                    state_d     = RESP;
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    adr_d       = '0;
                    wdat_d      = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ~wb.ack;
                    rsp_dat_d   = (wb.ack && !we_q) ? wb.rdat : '0;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            IRQ: begin
                if (irq_i || tmo_hit) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ~irq_i;
                    rsp_dat_d   = '0;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_op_d    = OP_WRITE;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            wdat_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_op_q    <= OP_WRITE;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_op_q    <= rsp_op_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            tmo_q       <= tmo_d;
        end
    end

    assign wb.cyc      = cyc_q;
    assign wb.stb      = cyc_q;
    assign wb.we       = we_q;
    assign wb.adr      = adr_q;
    assign wb.wdat     = wdat_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_op_o    = rsp_op_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: vector table for single commands plus
// sequences for reset, FIFO back-pressure and in-order response draining.
module tb_wb_cmd_master;
    localparam int unsigned AW = 2;
    localparam int unsigned DW = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;
    logic          rsp_valid, rsp_ready;
    logic [1:0]    rsp_op;
    logic [DW-1:0] rsp_dat;
    logic          rsp_err;
    logic          irq, busy;
    logic [2:0]    fifo_count;

    wb_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb_bus ();

    wb_cmd_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TMO)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_adr_i    (cmd_adr),
        .cmd_dat_i    (cmd_dat),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_op_o     (rsp_op),
        .rsp_dat_o    (rsp_dat),
        .rsp_err_o    (rsp_err),
        .wb           (wb_bus),
        .irq_i        (irq),
        .busy_o       (busy),
        .fifo_count_o (fifo_count)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] op, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_adr   = adr;
        cmd_dat   = dat;
        tick();
        cmd_valid = 1'b0;
        cmd_dat   = '0;
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        int            ack_at;    // cyc_o-high sample on which slave raises ack (0: never)
        int            irq_at;    // sample after push on which irq pulses (0: never)
        logic          ack_noise; // hold ack high although no bus cycle runs
        logic [DW-1:0] rdat;
        logic [DW-1:0] e_dat;
        logic          e_err;
        int            e_cyc;     // cycles cyc_o stays high
        int            e_lat;     // samples from push edge to rsp_valid
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input int idx, input vec_t v);
        int            cyc_n;
        int            lat;
        int            bus_bad;
        bit            got;
        logic          e_we;
        logic [DW-1:0] e_wdat;
        string         tag;
        cyc_n   = 0;
        lat     = 0;
        bus_bad = 0;
        got     = 0;
        e_we    = (v.op == 2'b00);
        e_wdat  = e_we ? v.dat : '0;
        tag     = $sformatf("v%0d", idx);
        push(v.op, v.adr, v.dat);
        for (int k = 1; k <= 30 && !got; k++) begin
            tick();
            irq = 1'b0;
            wb_bus.ack  = v.ack_noise;
            wb_bus.rdat = v.ack_noise ? v.rdat : '0;
            if (rsp_valid) begin
                got = 1;
                lat = k;
            end
            if (wb_bus.cyc) begin
                cyc_n++;
                if (wb_bus.stb !== 1'b1 || wb_bus.we !== e_we || wb_bus.adr !== v.adr ||
                    wb_bus.wdat !== e_wdat) bus_bad++;
                if (cyc_n == v.ack_at) begin
                    wb_bus.ack  = 1'b1;
                    wb_bus.rdat = v.rdat;
                end
            end
            if (v.irq_at == k) irq = 1'b1;
        end
        chk({tag, " latency"}, lat, v.e_lat);
        chk({tag, " cyc_cycles"}, cyc_n, v.e_cyc);
        chk({tag, " bus_fields"}, bus_bad, 0);
        chk({tag, " rsp_op"}, rsp_op, v.op);
        chk({tag, " rsp_dat"}, rsp_dat, v.e_dat);
        chk({tag, " rsp_err"}, rsp_err, v.e_err);
        chk({tag, " cyc_idle"}, wb_bus.cyc, 0);
        wb_bus.ack  = 1'b0;
        wb_bus.rdat = '0;
        irq         = 1'b0;
        rsp_ready   = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, " rsp_valid_drop"}, rsp_valid, 0);
        chk({tag, " busy_idle"}, busy, 0);
        tick();
    endtask

    logic [1:0]    q_op  [5];
    logic [AW-1:0] q_adr [5];
    logic [DW-1:0] q_dat [5];
    logic          q_err [5];

    initial begin
        int   n;
        int   viol;
        logic acc;

        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = '0;
        cmd_adr     = '0;
        cmd_dat     = '0;
        rsp_ready   = 1'b0;
        irq         = 1'b0;
        wb_bus.ack  = 1'b0;
        wb_bus.rdat = '0;

        //             op     adr    dat    ack irq nz   rdat   e_dat  err cyc lat
        vecs[0] = '{2'd0, 2'd2, 8'hA5, 3, 0, 1'b0, 8'h00, 8'h00, 1'b0, 3, 4};
        vecs[1] = '{2'd1, 2'd1, 8'h00, 1, 0, 1'b0, 8'h3C, 8'h3C, 1'b0, 1, 2};
        vecs[2] = '{2'd1, 2'd3, 8'h00, 0, 0, 1'b0, 8'hEE, 8'h00, 1'b1, 8, 9};
        vecs[3] = '{2'd1, 2'd0, 8'h00, 8, 0, 1'b0, 8'h5A, 8'h5A, 1'b0, 8, 9};
        vecs[4] = '{2'd0, 2'd1, 8'hFF, 0, 0, 1'b0, 8'h00, 8'h00, 1'b1, 8, 9};
        vecs[5] = '{2'd2, 2'd0, 8'h00, 0, 3, 1'b0, 8'h00, 8'h00, 1'b0, 0, 4};
        vecs[6] = '{2'd2, 2'd0, 8'h00, 0, 0, 1'b1, 8'hAA, 8'h00, 1'b1, 0, 9};
        vecs[7] = '{2'd2, 2'd3, 8'h00, 0, 8, 1'b0, 8'h00, 8'h00, 1'b0, 0, 9};
        vecs[8] = '{2'd3, 2'd2, 8'h55, 0, 0, 1'b0, 8'h00, 8'h00, 1'b1, 0, 1};

        // Reset state while held.
        #3;
        chk("rst cyc", wb_bus.cyc, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst cmd_ready", cmd_ready, 0);
        chk("rst busy", busy, 0);
        chk("rst fifo_count", fifo_count, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post-rst cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Back-pressure: slave acks at once, responses stall until rsp_ready.
        q_op  = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1};
        q_adr = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        q_dat = '{8'h00, 8'h77, 8'h00, 8'h00, 8'h77};
        q_err = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        wb_bus.ack  = 1'b1;
        wb_bus.rdat = 8'h77;
        n = 0;
        for (int k = 0; k < 20 && n < 5; k++) begin
            cmd_valid = 1'b1;
            cmd_op    = q_op[n];
            cmd_adr   = q_adr[n];
            cmd_dat   = 8'h10 + 8'(n);
            acc       = cmd_ready;
            tick();
            if (acc) n++;
        end
        chk("bp pushed", n, 5);
        cmd_op  = 2'd0;
        cmd_adr = 2'd2;
        tick();
        tick();
        tick();
        chk("bp fifo_count", fifo_count, 4);
        chk("bp cmd_ready", cmd_ready, 0);
        chk("bp busy", busy, 1);
        chk("bp rsp_valid", rsp_valid, 1);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 60 && n < 5; k++) begin
            if (rsp_valid) begin
                chk($sformatf("bp r%0d op", n), rsp_op, q_op[n]);
                chk($sformatf("bp r%0d dat", n), rsp_dat, q_dat[n]);
                chk($sformatf("bp r%0d err", n), rsp_err, q_err[n]);
                n++;
            end
            tick();
        end
        chk("bp responses", n, 5);
        chk("bp drained", fifo_count, 0);
        rsp_ready   = 1'b0;
        wb_bus.ack  = 1'b0;
        wb_bus.rdat = '0;
        tick();

        // Reset in the middle of a bus cycle with another command queued.
        push(2'd1, 2'd2, 8'h00);
        push(2'd0, 2'd1, 8'h99);
        tick();
        chk("mid cyc_high", wb_bus.cyc, 1);
        chk("mid fifo_count", fifo_count, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async cyc", wb_bus.cyc, 0);
        chk("async stb", wb_bus.stb, 0);
        chk("async rsp_valid", rsp_valid, 0);
        chk("async fifo_count", fifo_count, 0);
        chk("async busy", busy, 0);
        tick();
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        viol = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (rsp_valid || wb_bus.cyc || busy) viol++;
        end
        chk("no stale activity", viol, 0);
        chk("final cmd_ready", cmd_ready, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
